// File: rtl/pit_bus_rw_logic_pkg.sv
// 8254 CPU read/write logic: shared encodings.
// RW field codes, address/select constants, status and control-word bit positions.
package pit_pkg;

  typedef enum logic [1:0] {
    RW_LATCH = 2'b00,
    RW_LSB   = 2'b01,
    RW_MSB   = 2'b10,
    RW_WORD  = 2'b11
  } rw_e;

  localparam logic [1:0] ADDR_CW     = 2'b11;
  localparam logic [1:0] SC_READBACK = 2'b11;

  localparam int ST_OUT    = 7;
  localparam int ST_NULL   = 6;
  localparam int CW_RW_HI  = 5;
  localparam int CW_RW_LO  = 4;
  localparam int RB_NO_CNT = 5;
  localparam int RB_NO_STS = 4;

  function automatic rw_e cw_rw(input logic [5:0] cw);
    return rw_e'(cw[CW_RW_HI:CW_RW_LO]);
  endfunction

endpackage

// File: rtl/pit_bus_rw_logic_if.sv
// 8254 CPU bus: chip select, strobes, address and data.
// The CPU drives it as master; the read/write logic is the slave.
interface pit_bus_rw_logic_if;
  logic       CS;
  logic       RD;
  logic       WR;
  logic [1:0] A;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       data_oe;

  modport master (
    output CS, RD, WR, A, data_in,
    input  data_out, data_oe
  );

  modport slave (
    input  CS, RD, WR, A, data_in,
    output data_out, data_oe
  );
endinterface

// File: rtl/pit_counter_port.sv
// Per-counter CPU-side state: control word, byte pointers,
// output latch, status latch and the read byte mux.
module pit_counter_port
  import pit_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mode_wr,
  input  logic        latch_cnt,
  input  logic        latch_sts,
  input  logic        byte_wr,
  input  logic        rd_done,
  input  logic [5:0]  mode,
  input  logic [15:0] count,
  input  logic        out,
  input  logic        null_cnt,
  output logic [5:0]  cw,
  output logic        cw_wr,
  output logic        lsb_wr,
  output logic        msb_wr,
  output logic        cnt_wr,
  output logic [7:0]  rdata
);

  rw_e         rw;
  logic        wr_ptr;
  logic        rd_ptr;
  logic        ol_vld;
  logic        st_vld;
  logic [15:0] ol;
  logic [7:0]  st;
  logic [15:0] src;
  logic        hi;

  assign rw = cw_rw(cw);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cw     <= '0;
      cw_wr  <= 1'b0;
      lsb_wr <= 1'b0;
      msb_wr <= 1'b0;
      cnt_wr <= 1'b0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      ol_vld <= 1'b0;
      st_vld <= 1'b0;
      ol     <= '0;
      st     <= '0;
    end else begin
      cw_wr  <= 1'b0;
      lsb_wr <= 1'b0;
      msb_wr <= 1'b0;
      cnt_wr <= 1'b0;
      if (mode_wr) begin
        cw     <= mode;
        cw_wr  <= 1'b1;
        wr_ptr <= 1'b0;
        rd_ptr <= 1'b0;
        ol_vld <= 1'b0;
        st_vld <= 1'b0;
      end
      // A held latch ignores further latch commands until read out
      if (latch_cnt && !ol_vld) begin
        ol     <= count;
        ol_vld <= 1'b1;
      end
      if (latch_sts && !st_vld) begin
        st[ST_OUT]  <= out;
        st[ST_NULL] <= null_cnt;
        st[5:0]     <= cw;
        st_vld      <= 1'b1;
      end
      if (byte_wr) begin
        unique case (1'b1)
          (rw == RW_LATCH): ;
          (rw == RW_LSB): begin
            lsb_wr <= 1'b1;
            cnt_wr <= 1'b1;
          end
          (rw == RW_MSB): begin
            msb_wr <= 1'b1;
            cnt_wr <= 1'b1;
          end
          (rw == RW_WORD): begin
            lsb_wr <= !wr_ptr;
            msb_wr <= wr_ptr;
            cnt_wr <= wr_ptr;
            wr_ptr <= !wr_ptr;
          end
        endcase
      end
      if (rd_done) begin
        if (st_vld) begin
          st_vld <= 1'b0;
        end else if (rw == RW_WORD) begin
          rd_ptr <= !rd_ptr;
          if (rd_ptr) ol_vld <= 1'b0;
        end else if (rw != RW_LATCH) begin
          ol_vld <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    src   = ol_vld ? ol : count;
    hi    = (rw == RW_MSB) || ((rw == RW_WORD) && rd_ptr);
    rdata = 8'h00;
    if (st_vld)
      rdata = st;
    else if (rw != RW_LATCH)
      rdata = hi ? src[15:8] : src[7:0];
  end

endmodule

// File: rtl/pit_bus_rw_logic.sv
// 8254 CPU read/write logic: strobe edge detect, command decode
// and read-data steering across the three counter ports.
module pit_bus_rw_logic
  import pit_pkg::*;
#(
  parameter int NUM_CNT   = 3,
  parameter bit RB_ENABLE = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pit_bus_rw_logic_if.slave    bus,
  input  logic [16*NUM_CNT-1:0] current_count,
  input  logic [NUM_CNT-1:0]   OUT,
  input  logic [NUM_CNT-1:0]   null_count,
  output logic [6*NUM_CNT-1:0] control_word,
  output logic [NUM_CNT-1:0]   cw_wr,
  output logic [7:0]           cr_data,
  output logic [NUM_CNT-1:0]   cr_lsb_wr,
  output logic [NUM_CNT-1:0]   cr_msb_wr,
  output logic [NUM_CNT-1:0]   count_written
);

  logic       cs_q;
  logic       rd_q;
  logic       wr_q;
  logic [1:0] a_q;
  logic [7:0] d_q;
  logic       wr_commit;
  logic       rd_commit;
  logic       cw_cmd;
  logic       rb_cmd;
  logic [1:0] sc;
  rw_e        rw;

  logic [NUM_CNT-1:0]      mode_wr;
  logic [NUM_CNT-1:0]      latch_cnt;
  logic [NUM_CNT-1:0]      latch_sts;
  logic [NUM_CNT-1:0]      byte_wr;
  logic [NUM_CNT-1:0]      rd_done;
  logic [NUM_CNT-1:0][7:0] rdata;

  // Strobe copies reset inactive so reset release never looks like a commit
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cs_q <= 1'b1;
      rd_q <= 1'b1;
      wr_q <= 1'b1;
      a_q  <= '0;
      d_q  <= '0;
    end else begin
      cs_q <= bus.CS;
      rd_q <= bus.RD;
      wr_q <= bus.WR;
      a_q  <= bus.A;
      d_q  <= bus.data_in;
    end
  end

  assign wr_commit = !wr_q && bus.WR && !cs_q && rd_q;
  assign rd_commit = !rd_q && bus.RD && !cs_q && wr_q;
  assign sc        = d_q[7:6];
  assign rw        = rw_e'(d_q[CW_RW_HI:CW_RW_LO]);
  assign cw_cmd    = wr_commit && (a_q == ADDR_CW);
  assign rb_cmd    = cw_cmd && RB_ENABLE && (sc == SC_READBACK);

  always_ff @(posedge clk) begin
    if (!rst_n)
      cr_data <= '0;
    else if (wr_commit && (a_q != ADDR_CW))
      cr_data <= d_q;
  end

  for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
    assign mode_wr[i]   = cw_cmd && (sc == 2'(i)) && (rw != RW_LATCH);
    assign latch_cnt[i] = (cw_cmd && (sc == 2'(i)) && (rw == RW_LATCH))
                       || (rb_cmd && !d_q[RB_NO_CNT] && d_q[i+1]);
    assign latch_sts[i] = rb_cmd && !d_q[RB_NO_STS] && d_q[i+1];
    assign byte_wr[i]   = wr_commit && (a_q == 2'(i));
    assign rd_done[i]   = rd_commit && (a_q == 2'(i));

    pit_counter_port u_port (
      .clk      (clk),
      .rst_n    (rst_n),
      .mode_wr  (mode_wr[i]),
      .latch_cnt(latch_cnt[i]),
      .latch_sts(latch_sts[i]),
      .byte_wr  (byte_wr[i]),
      .rd_done  (rd_done[i]),
      .mode     (d_q[5:0]),
      .count    (current_count[16*i +: 16]),
      .out      (OUT[i]),
      .null_cnt (null_count[i]),
      .cw       (control_word[6*i +: 6]),
      .cw_wr    (cw_wr[i]),
      .lsb_wr   (cr_lsb_wr[i]),
      .msb_wr   (cr_msb_wr[i]),
      .cnt_wr   (count_written[i]),
      .rdata    (rdata[i])
    );
  end

  assign bus.data_oe = !bus.CS && !bus.RD && bus.WR
                    && (bus.A != ADDR_CW);

  always_comb begin
    bus.data_out = 8'h00;
    for (int i = 0; i < NUM_CNT; i++)
      if (bus.data_oe && (bus.A == 2'(i)))
        bus.data_out = bus.data_out | rdata[i];
  end

endmodule

// File: tb/tb_pit_bus_rw_logic.sv
// Directed bench for the 8254 CPU read/write logic.
// Hand-computed expectations checked with immediate assertions.
module tb_pit_bus_rw_logic;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [47:0] current_count = '0;
  logic [2:0]  OUT = '0;
  logic [2:0]  null_count = '0;
  logic [17:0] control_word;
  logic [2:0]  cw_wr;
  logic [7:0]  cr_data;
  logic [2:0]  cr_lsb_wr;
  logic [2:0]  cr_msb_wr;
  logic [2:0]  count_written;

  int n_cmp = 0;
  int n_err = 0;

  pit_bus_rw_logic_if bus ();

  pit_bus_rw_logic dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .current_count(current_count),
    .OUT          (OUT),
    .null_count   (null_count),
    .control_word (control_word),
    .cw_wr        (cw_wr),
    .cr_data      (cr_data),
    .cr_lsb_wr    (cr_lsb_wr),
    .cr_msb_wr    (cr_msb_wr),
    .count_written(count_written)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Returns #1 after the commit edge, while the pulses are valid
  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.CS = 1'b0; bus.A = a; bus.data_in = d; bus.WR = 1'b0;
    @(negedge clk);
    bus.WR = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [1:0] a, input logic [7:0] exp,
                    input string tag);
    @(negedge clk);
    bus.CS = 1'b0; bus.A = a; bus.RD = 1'b0;
    #1;
    chk({tag, "_oe"}, 32'(bus.data_oe), 32'h1);
    chk(tag, 32'(bus.data_out), 32'(exp));
    @(negedge clk);
    bus.RD = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_pulses(input string tag, input logic [2:0] c,
                            input logic [2:0] l, input logic [2:0] m,
                            input logic [2:0] w);
    chk({tag, "_cw_wr"}, 32'(cw_wr), 32'(c));
    chk({tag, "_lsb"}, 32'(cr_lsb_wr), 32'(l));
    chk({tag, "_msb"}, 32'(cr_msb_wr), 32'(m));
    chk({tag, "_cnt_wr"}, 32'(count_written), 32'(w));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    bus.CS = 1'b1; bus.RD = 1'b1; bus.WR = 1'b1;
    bus.A = 2'b00; bus.data_in = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cw", 32'(control_word), 32'h0);
    chk_pulses("rst", 3'b000, 3'b000, 3'b000, 3'b000);
    chk("rst_oe", 32'(bus.data_oe), 32'h0);
    chk("rst_cr_data", 32'(cr_data), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Counter 0 in LSB/MSB mode 2, count 0x2710
    wr(2'b11, 8'h34);
    chk_pulses("t1_cw", 3'b001, 3'b000, 3'b000, 3'b000);
    chk("t1_cw0", 32'(control_word[5:0]), 32'h34);
    wr(2'b00, 8'h10);
    chk_pulses("t1_lsb", 3'b000, 3'b001, 3'b000, 3'b000);
    chk("t1_lsb_data", 32'(cr_data), 32'h10);
    wr(2'b00, 8'h27);
    chk_pulses("t1_msb", 3'b000, 3'b000, 3'b001, 3'b001);
    chk("t1_msb_data", 32'(cr_data), 32'h27);
    @(posedge clk);
    #1;
    chk_pulses("t1_gone", 3'b000, 3'b000, 3'b000, 3'b000);

    // Counter 1 latch, count moves, then read latched word and live LSB
    wr(2'b11, 8'h70);
    chk("t2_cw1", 32'(control_word[11:6]), 32'h30);
    current_count[31:16] = 16'h1234;
    wr(2'b11, 8'h40);
    chk_pulses("t2_latch", 3'b000, 3'b000, 3'b000, 3'b000);
    current_count[31:16] = 16'h1000;
    rd(2'b01, 8'h34, "t2_rd0");
    rd(2'b01, 8'h12, "t2_rd1");
    rd(2'b01, 8'h00, "t2_rd_live");

    // Second counter-latch while held is ignored
    current_count[15:0] = 16'hABCD;
    wr(2'b11, 8'h00);
    current_count[15:0] = 16'h0001;
    wr(2'b11, 8'h00);
    rd(2'b00, 8'hCD, "t3_rd0");
    rd(2'b00, 8'hAB, "t3_rd1");
    rd(2'b00, 8'h01, "t3_rd_live");

    // Read-back of counter 2: status then latched count
    wr(2'b11, 8'h96);
    OUT = 3'b100;
    null_count = 3'b000;
    current_count[47:32] = 16'h5A3C;
    wr(2'b11, 8'hC8);
    current_count[47:32] = 16'h7788;
    rd(2'b10, 8'h96, "t4_sts");
    rd(2'b10, 8'h3C, "t4_ol");
    rd(2'b10, 8'h88, "t4_live");
    wr(2'b11, 8'hE8);
    rd(2'b10, 8'h96, "t4_sts2");
    rd(2'b10, 8'h88, "t4_live2");

    // Reset in the middle of a two-byte count
    wr(2'b11, 8'h30);
    wr(2'b00, 8'h55);
    chk_pulses("t5_pre", 3'b000, 3'b001, 3'b000, 3'b000);
    @(negedge clk);
    bus.CS = 1'b1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk_pulses("t5_rst", 3'b000, 3'b000, 3'b000, 3'b000);
    chk("t5_rst_cw", 32'(control_word), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    wr(2'b11, 8'h30);
    chk_pulses("t5_cw", 3'b001, 3'b000, 3'b000, 3'b000);
    wr(2'b00, 8'h01);
    chk_pulses("t5_b0", 3'b000, 3'b001, 3'b000, 3'b000);
    chk("t5_b0_data", 32'(cr_data), 32'h01);
    wr(2'b00, 8'h02);
    chk_pulses("t5_b1", 3'b000, 3'b000, 3'b001, 3'b001);
    chk("t5_b1_data", 32'(cr_data), 32'h02);

    // Illegal RD+WR together: no drive, no commit
    @(negedge clk);
    bus.CS = 1'b0; bus.A = 2'b00; bus.data_in = 8'h99;
    bus.WR = 1'b0; bus.RD = 1'b0;
    #1;
    chk("t6_oe", 32'(bus.data_oe), 32'h0);
    @(negedge clk);
    bus.WR = 1'b1; bus.RD = 1'b1;
    @(posedge clk);
    #1;
    chk_pulses("t6_illegal", 3'b000, 3'b000, 3'b000, 3'b000);

    // Write to unprogrammed counter 1 is ignored
    wr(2'b01, 8'h42);
    chk_pulses("t6_rw00", 3'b000, 3'b000, 3'b000, 3'b000);

    // A=11 read never drives
    @(negedge clk);
    bus.A = 2'b11; bus.RD = 1'b0;
    #1;
    chk("t6_cw_rd_oe", 32'(bus.data_oe), 32'h0);
    @(negedge clk);
    bus.RD = 1'b1; bus.CS = 1'b1;
    repeat (2) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
